// File: rtl/collenda_mem_arbiter.sv
// rtl/collenda_mem_arbiter.sv - two-master arbiter for one single-port RAM
// Round-robin or fixed priority with starvation guard, read-modify-write lock, and owner-tagged read return.
module collenda_mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic                m0_lock,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic                m1_lock,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int         LAST     = READ_LATENCY - 1;
  localparam logic [7:0] STARVE_L = 8'(STARVE_LIMIT);

  logic                    clken_q, clken_d;
  logic                    last_q, last_d;          // 0 = m0, 1 = m1
  logic                    lock_vld_q, lock_vld_d;
  logic                    lock_id_q, lock_id_d;
  logic [7:0]              starve_q, starve_d;
  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [READ_LATENCY-1:0] rd_id_q, rd_id_d;

  logic req0, req1, gnt0, gnt1, pick1, wr_sel;

  always_comb begin
    req0  = m0_read | m0_write;
    req1  = m1_read | m1_write;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    pick1 = 1'b0;
    if (!clken_q) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (lock_vld_q) begin
      gnt0 = !lock_id_q && req0;
      gnt1 = lock_id_q && req1;
    end else if (req0 && req1) begin
      if (FIXED_PRIO != 0) pick1 = (starve_q >= STARVE_L);
      else                 pick1 = !last_q;
      gnt1 = pick1;
      gnt0 = !pick1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // A grant is an accept: waitrequest drops exactly for the granted requester.
  assign m0_waitrequest = !clken_q || (req0 && !gnt0);
  assign m1_waitrequest = !clken_q || (req1 && !gnt1);

  assign wr_sel         = gnt1 ? m1_write : m0_write;
  assign mem_address    = gnt1 ? m1_address : m0_address;
  assign mem_writedata  = gnt1 ? m1_writedata : m0_writedata;
  assign mem_byteenable = wr_sel ? (gnt1 ? m1_byteenable : m0_byteenable) : '1;
  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = (gnt0 | gnt1) & wr_sel;
  assign mem_clken      = clken_q;

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_vld_q[LAST] && !rd_id_q[LAST];
  assign m1_readdatavalid = rd_vld_q[LAST] && rd_id_q[LAST];

  always_comb begin
    clken_d    = 1'b1;
    last_d     = last_q;
    lock_vld_d = lock_vld_q;
    lock_id_d  = lock_id_q;
    starve_d   = starve_q;
    rd_vld_d   = rd_vld_q;
    rd_id_d    = rd_id_q;

    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;

    if (lock_vld_q) begin
      if ((!lock_id_q && !m0_lock && (gnt0 || !req0)) ||
          ( lock_id_q && !m1_lock && (gnt1 || !req1)))
        lock_vld_d = 1'b0;
    end else if (gnt0 && m0_lock) begin
      lock_vld_d = 1'b1;
      lock_id_d  = 1'b0;
    end else if (gnt1 && m1_lock) begin
      lock_vld_d = 1'b1;
      lock_id_d  = 1'b1;
    end

    if (gnt1)                                   starve_d = 8'd0;
    else if (clken_q && req1 && starve_q != 8'hFF) starve_d = starve_q + 8'd1;

    // Write wins when read and write are both raised, so such a cycle returns no data.
    for (int i = LAST; i > 0; i--) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_id_d[i]  = rd_id_q[i-1];
    end
    rd_vld_d[0] = (gnt0 && m0_read && !m0_write) || (gnt1 && m1_read && !m1_write);
    rd_id_d[0]  = gnt1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clken_q    <= 1'b0;
      last_q     <= 1'b1;
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
      starve_q   <= 8'd0;
      rd_vld_q   <= '0;
      rd_id_q    <= '0;
    end else begin
      clken_q    <= clken_d;
      last_q     <= last_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      starve_q   <= starve_d;
      rd_vld_q   <= rd_vld_d;
      rd_id_q    <= rd_id_d;
    end
  end

  m0_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
  m1_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule

// File: tb/tb_collenda_mem_arbiter.sv
// tb/tb_collenda_mem_arbiter.sv - self-checking bench for collenda_mem_arbiter
// Round-robin instance a and fixed-priority (STARVE_LIMIT=4) instance b share the master stimulus.
module tb_collenda_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;

  logic        a_w0, a_w1, a_v0, a_v1, a_cs, a_we, a_ck;
  logic [31:0] a_rd0, a_rd1, a_wd, a_q;
  logic [9:0]  a_addr;
  logic [3:0]  a_be;
  logic        b_w0, b_w1, b_v0, b_v1, b_cs, b_we, b_ck;
  logic [31:0] b_rd0, b_rd1, b_wd, b_q;
  logic [9:0]  b_addr;
  logic [3:0]  b_be;

  logic [31:0] ram_a [1024];
  logic [31:0] ram_b [1024];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  collenda_mem_arbiter #(.FIXED_PRIO(0)) dut_a (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_lock(m0_lock), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata), .m0_waitrequest(a_w0),
    .m0_readdata(a_rd0), .m0_readdatavalid(a_v0),
    .m1_read(m1_read), .m1_write(m1_write), .m1_lock(m1_lock), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata), .m1_waitrequest(a_w1),
    .m1_readdata(a_rd1), .m1_readdatavalid(a_v1),
    .mem_address(a_addr), .mem_byteenable(a_be), .mem_chipselect(a_cs), .mem_write(a_we),
    .mem_writedata(a_wd), .mem_clken(a_ck), .mem_readdata(a_q));

  collenda_mem_arbiter #(.FIXED_PRIO(1), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_lock(m0_lock), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata), .m0_waitrequest(b_w0),
    .m0_readdata(b_rd0), .m0_readdatavalid(b_v0),
    .m1_read(m1_read), .m1_write(m1_write), .m1_lock(m1_lock), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata), .m1_waitrequest(b_w1),
    .m1_readdata(b_rd1), .m1_readdatavalid(b_v1),
    .mem_address(b_addr), .mem_byteenable(b_be), .mem_chipselect(b_cs), .mem_write(b_we),
    .mem_writedata(b_wd), .mem_clken(b_ck), .mem_readdata(b_q));

  // Behavioural RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (a_cs) begin
      if (a_we) begin
        for (int k = 0; k < 4; k++) if (a_be[k]) ram_a[a_addr][8*k +: 8] <= a_wd[8*k +: 8];
      end else a_q <= ram_a[a_addr];
    end
    if (b_cs) begin
      if (b_we) begin
        for (int k = 0; k < 4; k++) if (b_be[k]) ram_b[b_addr][8*k +: 8] <= b_wd[8*k +: 8];
      end else b_q <= ram_b[b_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
    m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    tick();
  endtask

  typedef struct {
    logic       r0, w0, r1, w1;
    logic [9:0] ad0, ad1;
    logic [3:0] be0, be1;
    logic       ew0, ew1, ecs, ewe;
    logic [9:0] eaddr;
    logic [3:0] ebe;
  } vec_t;

  vec_t tbl [7];

  // Random-phase reference state: outstanding request per master and model memory.
  logic        p0, p1, pr0, pr1, ac0, ac1, exp_v0, exp_v1, last_acc;
  logic [9:0]  pa0, pa1;
  logic [3:0]  pb0, pb1;
  logic [31:0] pd0, pd1, exp_d;
  logic [31:0] model [16];
  int          cyc, hit;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  initial begin
    idle_in();
    //            r0 w0 r1 w1 ad0 ad1 be0 be1  ew0 ew1 ecs ewe eaddr ebe
    tbl[0] = '{0, 0, 0, 0, 0,  0,  0,  0,   0,  0,  0,  0,  0,  4'hF};
    tbl[1] = '{1, 0, 0, 0, 3,  0,  0,  0,   0,  0,  1,  0,  3,  4'hF};
    tbl[2] = '{1, 0, 1, 0, 4,  5,  0,  0,   1,  0,  1,  0,  5,  4'hF};
    tbl[3] = '{1, 0, 1, 0, 4,  5,  0,  0,   0,  1,  1,  0,  4,  4'hF};
    tbl[4] = '{0, 0, 0, 1, 0,  7,  0,  5,   0,  0,  1,  1,  7,  4'h5};
    tbl[5] = '{0, 1, 1, 0, 8,  9,  12, 0,   0,  1,  1,  1,  8,  4'hC};
    tbl[6] = '{0, 0, 0, 0, 0,  0,  0,  0,   0,  0,  0,  0,  0,  4'hF};

    // Reset state, with requests present to show they are ignored.
    m0_read = 1; m1_write = 1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("rst_w0", a_w0, 1); chk("rst_w1", a_w1, 1);
      chk("rst_v0", a_v0, 0); chk("rst_v1", a_v1, 0);
      chk("rst_cs", a_cs, 0); chk("rst_clken", a_ck, 0);
    end
    @(posedge clk); #1 reset = 0; idle_in();
    tick(); smp();
    chk("idle_w0", a_w0, 0); chk("idle_w1", a_w1, 0);
    chk("idle_clken", a_ck, 1); chk("idle_cs", a_cs, 0);

    // Vector table on the round-robin instance.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      m0_read = tbl[i].r0; m0_write = tbl[i].w0; m0_address = tbl[i].ad0; m0_byteenable = tbl[i].be0;
      m1_read = tbl[i].r1; m1_write = tbl[i].w1; m1_address = tbl[i].ad1; m1_byteenable = tbl[i].be1;
      m0_writedata = 32'h0A0A0A0A; m1_writedata = 32'h0B0B0B0B;
      smp();
      chk($sformatf("vec%0d_w0", i), a_w0, tbl[i].ew0);
      chk($sformatf("vec%0d_w1", i), a_w1, tbl[i].ew1);
      chk($sformatf("vec%0d_cs", i), a_cs, tbl[i].ecs);
      chk($sformatf("vec%0d_we", i), a_we, tbl[i].ewe);
      if (tbl[i].ecs) begin
        chk($sformatf("vec%0d_addr", i), a_addr, tbl[i].eaddr);
        chk($sformatf("vec%0d_be", i), a_be, tbl[i].ebe);
      end
      tick();
    end

    // Partial write then read-back through m1.
    do_reset();
    ram_a[5] = 32'h12345678;
    m1_write = 1; m1_address = 5; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'b0011;
    smp(); chk("wr_w1", a_w1, 0); chk("wr_we", a_we, 1);
    tick(); m1_write = 0; m1_read = 1;
    smp(); chk("rd_w1", a_w1, 0);
    tick(); m1_read = 0;
    smp();
    chk("rd_v1", a_v1, 1); chk("rd_v0", a_v0, 0); chk("rd_data", a_rd1, 32'h1234BEEF);

    // Round-robin alternation under continuous contention.
    do_reset();
    ram_a[32] = 32'hAAAA0000; ram_a[33] = 32'hBBBB1111;
    m0_read = 1; m0_address = 32; m1_read = 1; m1_address = 33;
    for (int c = 0; c < 8; c++) begin
      smp();
      chk($sformatf("rr%0d_w0", c), a_w0, (c % 2) != 0);
      chk($sformatf("rr%0d_w1", c), a_w1, (c % 2) == 0);
      if (c > 0) begin
        chk($sformatf("rr%0d_v0", c), a_v0, (c % 2) == 1);
        chk($sformatf("rr%0d_v1", c), a_v1, (c % 2) == 0);
        chk($sformatf("rr%0d_data", c), a_rd0, (c % 2) == 1 ? 32'hAAAA0000 : 32'hBBBB1111);
      end
      tick();
    end
    idle_in();

    // Fixed priority: m1 forced through on the fifth contended cycle, twice.
    do_reset();
    m0_read = 1; m1_read = 1;
    for (int round = 0; round < 2; round++) begin
      hit = 0;
      for (int c = 1; c <= 20 && hit == 0; c++) begin
        smp();
        if (!b_w1) hit = c;
        tick();
      end
      chk($sformatf("starve_round%0d", round), hit, 5);
      m1_read = 0; tick(); m1_read = 1;
    end
    idle_in();

    // Lock: m1 excluded from the locked read until the unlocking write.
    do_reset();
    m0_read = 1; m0_lock = 1; m0_address = 16;
    smp(); chk("lk_rd_w0", a_w0, 0);
    tick(); m0_read = 0; m1_read = 1; m1_address = 17;
    smp(); chk("lk_hold_w1", a_w1, 1); chk("lk_hold_cs", a_cs, 0); chk("lk_hold_v0", a_v0, 1);
    tick(); m0_write = 1; m0_lock = 0; m0_writedata = 32'h55; m0_byteenable = 4'hF;
    smp(); chk("lk_wr_w0", a_w0, 0); chk("lk_wr_w1", a_w1, 1); chk("lk_wr_we", a_we, 1);
    tick(); m0_write = 0;
    smp(); chk("lk_rel_w1", a_w1, 0);
    tick(); idle_in();

    // Reset straight after an accepted read: no response may surface.
    do_reset();
    m0_read = 1;
    smp(); chk("rf_acc", a_w0, 0);
    @(posedge clk); #1 reset = 1; m0_read = 0;
    hit = 0;
    for (int c = 0; c < 3; c++) begin smp(); hit += int'(a_v0) + int'(a_v1); end
    @(posedge clk); #1 reset = 0;
    for (int c = 0; c < 3; c++) begin smp(); hit += int'(a_v0) + int'(a_v1); end
    chk("rf_no_valid", hit, 0);

    // Random traffic against the scoreboard (round-robin instance).
    do_reset();
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom; ram_a[i] = model[i];
    end
    p0 = 0; p1 = 0; exp_v0 = 0; exp_v1 = 0; exp_d = 0; last_acc = 1;
    for (cyc = 0; cyc < 1500; cyc++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; pr0 = $urandom_range(0, 1) == 1; pa0 = 10'($urandom_range(0, 15));
        pb0 = 4'($urandom); pd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; pr1 = $urandom_range(0, 1) == 1; pa1 = 10'($urandom_range(0, 15));
        pb1 = 4'($urandom); pd1 = $urandom;
      end
      m0_read = p0 && pr0; m0_write = p0 && !pr0; m0_address = pa0; m0_byteenable = pb0; m0_writedata = pd0;
      m1_read = p1 && pr1; m1_write = p1 && !pr1; m1_address = pa1; m1_byteenable = pb1; m1_writedata = pd1;
      smp();
      chk("rnd_v0", a_v0, exp_v0);
      chk("rnd_v1", a_v1, exp_v1);
      if (exp_v0 || exp_v1) chk("rnd_data", a_rd0, exp_d);
      ac0 = p0 && !a_w0;
      ac1 = p1 && !a_w1;
      chk("rnd_accepts", int'(ac0) + int'(ac1), int'(p0 || p1));
      if (p0 && p1) chk("rnd_rr_winner", ac1, !last_acc);
      exp_v0 = ac0 && pr0;
      exp_v1 = ac1 && pr1;
      if (ac0) begin
        last_acc = 0;
        if (pr0) exp_d = model[pa0[3:0]]; else model[pa0[3:0]] = merge(model[pa0[3:0]], pd0, pb0);
      end
      if (ac1) begin
        last_acc = 1;
        if (pr1) exp_d = model[pa1[3:0]]; else model[pa1[3:0]] = merge(model[pa1[3:0]], pd1, pb1);
      end
      tick();
      if (ac0) p0 = 0;
      if (ac1) p1 = 0;
    end
    idle_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
